// File: rtl/l1_dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l1_cache_pkg
// Brief    : Shared state encoding, datapath widths and line field layout
//            for the direct-mapped write-back L1 data cache.
// Revision : 1.0 - initial release
// ============================================================================
package l1_cache_pkg;

  // Controller states; IDLE is the only state in which no L2 request is driven
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } state_t;

  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int OFFSET_W        = 2;
  localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;

  // Line layout, LSB first: data, tag, dirty, valid
  localparam int LINE_DATA_LSB = 0;
  localparam int LINE_TAG_LSB  = LINE_DATA_LSB + BLOCK_W;

  function automatic int line_dirty_pos(input int tag_w);
    return LINE_TAG_LSB + tag_w;
  endfunction

  function automatic int line_valid_pos(input int tag_w);
    return LINE_TAG_LSB + tag_w + 1;
  endfunction

  function automatic int line_width(input int tag_w);
    return BLOCK_W + tag_w + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/l1_dcache_if.sv
`default_nettype none
// ============================================================================
// Module   : l1_dcache_if
// Brief    : Processor-side and L2-side signal bundle of the L1 data cache.
//            The cache takes the slave view; pipeline/L2 take the master view.
// Revision : 1.0 - initial release
// ============================================================================
interface l1_dcache_if;
  import l1_cache_pkg::*;

  logic               proc_read;
  logic               proc_write;
  logic [29:0]        proc_addr;
  logic [WORD_W-1:0]  proc_wdata;
  logic [WORD_W-1:0]  proc_rdata;
  logic               proc_stall;
  logic               mem_read;
  logic               mem_write;
  logic [27:0]        mem_addr;
  logic [BLOCK_W-1:0] mem_wdata;
  logic [BLOCK_W-1:0] mem_rdata;
  logic               mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/l1_dcache_line_array.sv
`default_nettype none
// ============================================================================
// Module   : l1_line_array
// Brief    : Valid/dirty/tag/data storage for the L1 data cache. One
//            combinational read port, one write port (line fill, word write
//            with dirty set, or dirty clear after write-back).
// Revision : 1.0 - initial release
// ============================================================================
module l1_line_array
  import l1_cache_pkg::*;
#(
  parameter  int NUM_LINES = 8,
  parameter  int TAG_W     = 25,
  localparam int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic                clk,
  input  logic                rst,
  // read port
  input  logic [IDX_W-1:0]    rd_index,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [BLOCK_W-1:0]  rd_data,
  // write port
  input  logic [IDX_W-1:0]    wr_index,
  input  logic                fill_en,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data,
  input  logic                word_en,
  input  logic [OFFSET_W-1:0] word_sel,
  input  logic [WORD_W-1:0]   word_data,
  input  logic                clean_en
);

  localparam int LINE_W    = line_width(TAG_W);
  localparam int DIRTY_POS = line_dirty_pos(TAG_W);
  localparam int VALID_POS = line_valid_pos(TAG_W);

  logic [LINE_W-1:0] lines [NUM_LINES];
  logic [LINE_W-1:0] sel_line;

  assign sel_line = lines[rd_index];
  assign rd_valid = sel_line[VALID_POS];
  assign rd_dirty = sel_line[DIRTY_POS];
  assign rd_tag   = sel_line[LINE_TAG_LSB +: TAG_W];
  assign rd_data  = sel_line[LINE_DATA_LSB +: BLOCK_W];

  // Line updates: a fill replaces the whole line clean; a word write marks dirty
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        lines[i] <= '0;
      end
    end else if (fill_en) begin
      lines[wr_index] <= {1'b1, 1'b0, fill_tag, fill_data};
    end else if (word_en) begin
      lines[wr_index][LINE_DATA_LSB + WORD_W * int'(word_sel) +: WORD_W] <= word_data;
      lines[wr_index][DIRTY_POS] <= 1'b1;
    end else if (clean_en) begin
      lines[wr_index][DIRTY_POS] <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/l1_dcache.sv
`default_nettype none
// ============================================================================
// Module   : l1_dcache
// Brief    : Direct-mapped, write-back, write-allocate L1 data cache between
//            the MEM stage and L2. Hits complete with no stall; misses run a
//            write-back (if dirty) then an allocate, and the access replays
//            as a hit from IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module l1_dcache
  import l1_cache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int TAG_W     = 25
) (
  input  logic       clk,
  input  logic       proc_reset,
  l1_dcache_if.slave bus
);

  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int BADDR_W = TAG_W + IDX_W;

  state_t state, state_next;

  logic [OFFSET_W-1:0] req_off;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                req;
  logic                hit;
  logic                miss;

  // Block address of the access being serviced; frozen for the whole miss
  logic [BADDR_W-1:0]  miss_baddr;
  logic [IDX_W-1:0]    line_idx;

  logic                rd_valid;
  logic                rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [BLOCK_W-1:0]  rd_data;

  logic                fill_en;
  logic                word_en;
  logic                clean_en;

  logic                mem_read_c;
  logic                mem_write_c;
  logic [BADDR_W-1:0]  mem_addr_c;
  logic [BLOCK_W-1:0]  mem_wdata_c;

  assign req_off = bus.proc_addr[OFFSET_W-1:0];
  assign req_idx = bus.proc_addr[OFFSET_W +: IDX_W];
  assign req_tag = bus.proc_addr[OFFSET_W + IDX_W +: TAG_W];
  assign req     = bus.proc_read | bus.proc_write;

  // Outside IDLE the line under service is the one captured at miss time
  assign line_idx = (state == IDLE) ? req_idx : miss_baddr[IDX_W-1:0];

  assign hit  = rd_valid && (rd_tag == req_tag);
  assign miss = req && !hit;

  l1_line_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W)
  ) u_lines (
    .clk       (clk),
    .rst       (proc_reset),
    .rd_index  (line_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_index  (line_idx),
    .fill_en   (fill_en),
    .fill_tag  (miss_baddr[IDX_W +: TAG_W]),
    .fill_data (bus.mem_rdata),
    .word_en   (word_en),
    .word_sel  (req_off),
    .word_data (bus.proc_wdata),
    .clean_en  (clean_en)
  );

  // State register
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the missing block address when a miss is first seen in IDLE
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      miss_baddr <= '0;
    end else if ((state == IDLE) && miss) begin
      miss_baddr <= {req_tag, req_idx};
    end
  end

  // Next-state and Moore L2 request decode; hit writes merge only from IDLE
  always_comb begin
    state_next  = state;
    fill_en     = 1'b0;
    word_en     = 1'b0;
    clean_en    = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    case (state)
      IDLE: begin
        if (miss) begin
          state_next = (rd_valid && rd_dirty) ? WRITE_BACK : ALLOCATE;
        end else if (bus.proc_write) begin
          word_en = 1'b1;
        end
      end
      WRITE_BACK: begin
        mem_write_c = 1'b1;
        mem_addr_c  = {rd_tag, miss_baddr[IDX_W-1:0]};
        mem_wdata_c = rd_data;
        if (bus.mem_ready) begin
          clean_en   = 1'b1;
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_read_c = 1'b1;
        mem_addr_c = miss_baddr;
        if (bus.mem_ready) begin
          fill_en    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.mem_read   = mem_read_c;
  assign bus.mem_write  = mem_write_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.proc_rdata = rd_data[WORD_W * int'(req_off) +: WORD_W];
  assign bus.proc_stall = req && ((state != IDLE) || miss);

endmodule
`default_nettype wire

// File: tb/tb_l1_dcache.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_dcache
// Brief    : Self-checking bench for l1_dcache: behavioural L2 responder,
//            word-level reference memory, read-data scoreboard queue,
//            table-driven access vectors and hand-written miss sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1_dcache;
  import l1_cache_pkg::*;

  logic clk = 1'b0;
  logic proc_reset;
  always #5 clk = ~clk;

  l1_dcache_if bus();

  l1_dcache #(.NUM_LINES(8), .TAG_W(25)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .bus        (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Default memory image: word at word-address a holds {2'b10, a}
  function automatic logic [31:0] pat_word(input logic [29:0] waddr);
    return {2'b10, waddr};
  endfunction

  function automatic logic [127:0] pat_block(input logic [27:0] b);
    return {pat_word({b, 2'd3}), pat_word({b, 2'd2}), pat_word({b, 2'd1}), pat_word({b, 2'd0})};
  endfunction

  // Architectural truth seen by the processor
  logic [31:0] ref_mem [logic [29:0]];
  function automatic logic [31:0] ref_read(input logic [29:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat_word(a);
  endfunction
  function automatic logic [127:0] ref_block(input logic [27:0] b);
    return {ref_read({b, 2'd3}), ref_read({b, 2'd2}), ref_read({b, 2'd1}), ref_read({b, 2'd0})};
  endfunction

  // Backing store inside the L2 model, updated only by write-backs
  logic [127:0] l2_mem [logic [27:0]];
  function automatic logic [127:0] l2_block(input logic [27:0] b);
    return l2_mem.exists(b) ? l2_mem[b] : pat_block(b);
  endfunction

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } txn_t;
  txn_t obs[$];

  logic [31:0] exp_q[$];

  int l2_lat    = 2;
  bit l2_inject = 1'b0;

  // L2 responder: pulses mem_ready after l2_lat cycles of a held request
  initial begin
    int wait_cnt;
    txn_t t;
    wait_cnt      = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (l2_inject) begin
        l2_inject     = 1'b0;
        bus.mem_rdata = {4{32'hBAD0_BAD0}};
        bus.mem_ready = 1'b1;
      end else if (bus.mem_read || bus.mem_write) begin
        wait_cnt++;
        if (wait_cnt >= l2_lat) begin
          wait_cnt = 0;
          t.wr   = bus.mem_write;
          t.addr = bus.mem_addr;
          if (bus.mem_write) begin
            t.data = bus.mem_wdata;
            l2_mem[bus.mem_addr] = bus.mem_wdata;
          end else begin
            t.data        = l2_block(bus.mem_addr);
            bus.mem_rdata = t.data;
          end
          obs.push_back(t);
          bus.mem_ready = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // One processor access, called just after a rising edge; returns stall count
  task automatic access(input bit wr, input logic [29:0] addr, input logic [31:0] wdata,
                        output int stalls, output logic [31:0] rdata, output bit timed_out,
                        output int req_cycle, output logic [27:0] req_addr);
    stalls         = 0;
    timed_out      = 1'b0;
    req_cycle      = -1;
    req_addr       = '0;
    rdata          = '0;
    bus.proc_read  = !wr;
    bus.proc_write = wr;
    bus.proc_addr  = addr;
    bus.proc_wdata = wdata;
    forever begin
      @(negedge clk);
      if (!bus.proc_stall) begin
        rdata = bus.proc_rdata;
        break;
      end
      if (req_cycle < 0 && (bus.mem_read || bus.mem_write)) begin
        req_cycle = stalls;
        req_addr  = bus.mem_addr;
      end
      stalls++;
      if (stalls > 60) begin
        timed_out = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
  endtask

  // Read through the scoreboard: expectation queued at drive, popped on completion
  task automatic sb_read(input string name, input logic [29:0] addr, output int stalls);
    logic [31:0] rd;
    logic [31:0] exp;
    bit          to;
    int          rc;
    logic [27:0] ra;
    exp_q.push_back(ref_read(addr));
    access(1'b0, addr, '0, stalls, rd, to, rc, ra);
    check({name, " timeout"}, to, 1'b0);
    exp = exp_q.pop_front();
    check({name, " rdata"}, rd, exp);
  endtask

  typedef struct {
    bit          wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    int          exp_stalls;
    int          exp_rd;
    int          exp_wr;
  } vec_t;
  vec_t vecs[13];

  task automatic run_vec(input int i);
    int          st;
    int          nr;
    int          nw;
    logic [31:0] rd;
    logic [31:0] exp;
    bit          to;
    int          rc;
    logic [27:0] ra;
    obs.delete();
    if (!vecs[i].wr) exp_q.push_back(ref_read(vecs[i].addr));
    access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, st, rd, to, rc, ra);
    check($sformatf("vec%0d timeout", i), to, 1'b0);
    if (vecs[i].wr) begin
      ref_mem[vecs[i].addr] = vecs[i].wdata;
    end else begin
      exp = exp_q.pop_front();
      check($sformatf("vec%0d rdata", i), rd, exp);
    end
    nr = 0;
    nw = 0;
    foreach (obs[k]) begin
      if (obs[k].wr) nw++;
      else nr++;
    end
    check($sformatf("vec%0d stalls", i), st, vecs[i].exp_stalls);
    check($sformatf("vec%0d l2 reads", i), nr, vecs[i].exp_rd);
    check($sformatf("vec%0d l2 writes", i), nw, vecs[i].exp_wr);
  endtask

  // Watchdog so the bench always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st;
    int          rc;
    bit          to;
    bit          got;
    logic [31:0] rd;
    logic [27:0] ra;
    logic [127:0] exp_wb;

    // Lines: clean miss latency 2 -> 3 stalls, dirty miss -> 5 stalls
    vecs[0]  = '{1'b1, 30'h006, 32'hDEAD_BEEF, 0, 0, 0};
    vecs[1]  = '{1'b0, 30'h006, 32'h0,         0, 0, 0};
    vecs[2]  = '{1'b0, 30'h005, 32'h0,         0, 0, 0};
    vecs[3]  = '{1'b1, 30'h00C, 32'h1111_2222, 3, 1, 0};
    vecs[4]  = '{1'b0, 30'h00C, 32'h0,         0, 0, 0};
    vecs[5]  = '{1'b0, 30'h00F, 32'h0,         0, 0, 0};
    vecs[6]  = '{1'b0, 30'h00C, 32'h0,         3, 1, 0};
    vecs[7]  = '{1'b0, 30'h07C, 32'h0,         3, 1, 0};
    vecs[8]  = '{1'b1, 30'h07D, 32'h0000_A5A5, 0, 0, 0};
    vecs[9]  = '{1'b0, 30'h0FC, 32'h0,         5, 1, 1};
    vecs[10] = '{1'b0, 30'h07D, 32'h0,         3, 1, 0};
    vecs[11] = '{1'b0, 30'h024, 32'h0,         5, 1, 1};
    vecs[12] = '{1'b0, 30'h006, 32'h0,         3, 1, 0};

    proc_reset     = 1'b1;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    proc_reset = 1'b0;

    check("reset mem_read",   bus.mem_read,   1'b0);
    check("reset mem_write",  bus.mem_write,  1'b0);
    check("reset mem_addr",   bus.mem_addr,   28'h0);
    check("reset mem_wdata",  bus.mem_wdata,  128'h0);
    check("reset proc_rdata", bus.proc_rdata, 32'h0);
    check("reset proc_stall", bus.proc_stall, 1'b0);

    // First fill: L2 answers in the third request cycle
    l2_lat = 3;
    obs.delete();
    exp_q.push_back(ref_read(30'h004));
    access(1'b0, 30'h004, '0, st, rd, to, rc, ra);
    check("fill timeout", to, 1'b0);
    check("fill rdata D0", rd, exp_q.pop_front());
    check("fill stalls", st, 4);
    check("fill req cycle", rc, 1);
    check("fill mem_addr", ra, 28'h000_0001);
    check("fill l2 txns", obs.size(), 1);
    l2_lat = 2;
    sb_read("repeat hit", 30'h004, st);
    check("repeat hit stalls", st, 0);

    for (int i = 0; i <= 5; i++) run_vec(i);

    // Dirty victim at index 3 replaced by a different tag
    obs.delete();
    exp_wb = ref_block(28'h000_0003);
    sb_read("dirty miss", 30'h02C, st);
    check("dirty miss stalls", st, 5);
    check("dirty miss txns", obs.size(), 2);
    if (obs.size() == 2) begin
      check("wb is write", obs[0].wr, 1'b1);
      check("wb addr", obs[0].addr, 28'h000_0003);
      check("wb data", obs[0].data, exp_wb);
      check("alloc is read", obs[1].wr, 1'b0);
      check("alloc addr", obs[1].addr, 28'h000_000B);
    end

    for (int i = 6; i <= 12; i++) run_vec(i);

    // Reset while ALLOCATE waits on L2
    l2_lat        = 20;
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h100;
    repeat (3) @(posedge clk);
    #1;
    check("alloc mem_read", bus.mem_read, 1'b1);
    check("alloc mem_addr", bus.mem_addr, 28'h000_0040);
    proc_reset    = 1'b1;
    bus.proc_read = 1'b0;
    @(posedge clk);
    #1;
    proc_reset = 1'b0;
    check("rst mid mem_read",   bus.mem_read,   1'b0);
    check("rst mid mem_write",  bus.mem_write,  1'b0);
    check("rst mid mem_addr",   bus.mem_addr,   28'h0);
    check("rst mid mem_wdata",  bus.mem_wdata,  128'h0);
    check("rst mid proc_stall", bus.proc_stall, 1'b0);
    check("rst mid proc_rdata", bus.proc_rdata, 32'h0);
    l2_lat = 2;
    @(posedge clk);
    #1;
    sb_read("post reset", 30'h006, st);
    check("post reset misses", st, 3);

    // Request dropped while ALLOCATE waits five cycles
    l2_lat = 5;
    obs.delete();
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h040;
    repeat (2) @(posedge clk);
    #1;
    bus.proc_read = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(posedge clk);
      #1;
      if (obs.size() > 0) got = 1'b1;
    end
    check("drop fill done", got, 1'b1);
    check("drop back idle", bus.mem_read, 1'b0);
    check("drop no stall", bus.proc_stall, 1'b0);
    if (obs.size() > 0) check("drop fill addr", obs[0].addr, 28'h000_0010);

    // Stray mem_ready in IDLE must be ignored
    l2_inject = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle ready mem_read",  bus.mem_read,  1'b0);
    check("idle ready mem_write", bus.mem_write, 1'b0);
    check("idle ready no txn",    obs.size(),    1);
    sb_read("dropped line hit", 30'h040, st);
    check("dropped line stalls", st, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
